fetch_unit: RTL and testbench

Instruction fetch stage of the single-issue RISC-V core; sits directly upstream of the control unit and decode, supplying the instruction word it decodes. Owns the program counter, issues one instruction-memory read at a time, buffers the returned word until decode accepts it, and applies PC redirects (taken branches/jumps) from the execute side. Tolerates variable memory latency and downstream back-pressure.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_pc_reg.sv | 30 +++
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types and constants
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with aligned load, increment and hold
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4
);

  assign pc_plus4 = pc + ADDR_WIDTH'(INSTR_BYTES);

  // load beats inc so a redirect never coincides with a sequential advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= {target[ADDR_WIDTH-1:2], 2'b00};
    end else if (inc) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: single outstanding imem read, one-entry buffer
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  PCTarget_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic [ADDR_WIDTH-1:0]  pcplus4_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i
);

  fetch_state_t           state;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  pc_plus4;

  fetch_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (redirect_i),
    .inc      ((state == HOLD) && instr_ready_i),
    .target   (PCTarget_i),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  // reset shares the ISSUE encoding, so the request is gated until rst drops
  assign imem_req_o    = (state == ISSUE) && !rst;
  assign imem_addr_o   = pc;
  assign pc_o          = pc;
  assign pcplus4_o     = pc_plus4;
  assign instr_o       = instr_q;
  assign instr_valid_o = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ISSUE;
      instr_q <= '0;
    end else begin
      case (state)
        ISSUE:   state <= redirect_i ? DISCARD : WAIT;
        WAIT: begin
          if (redirect_i) begin
            state <= imem_rvalid_i ? ISSUE : DISCARD;
          end else if (imem_rvalid_i) begin
            instr_q <= imem_rdata_i;
            state   <= HOLD;
          end
        end
        // the stale response still has to drain before a new request goes out
        DISCARD: if (imem_rvalid_i) state <= ISSUE;
        HOLD:    if (redirect_i || instr_ready_i) state <= ISSUE;
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a fixed-latency memory model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] PCTarget_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pcplus4_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 1;
  int          cnt;
  logic [31:0] pend_addr;
  logic        saw_valid;

  fetch_unit #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .PCTarget_i    (PCTarget_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pcplus4_o     (pcplus4_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  // memory answers with the request address as data, lat cycles after the request
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 0;
      pend_addr <= '0;
    end else if (imem_req_o) begin
      cnt       <= lat;
      pend_addr <= imem_addr_o;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end
  assign imem_rvalid_i = (cnt == 1);
  assign imem_rdata_i  = pend_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag, input int budget);
    int i = 0;
    saw_valid = 1'b0;
    while (!imem_req_o && i < budget) begin
      @(negedge clk);
      saw_valid = saw_valid | instr_valid_o;
      i++;
    end
    check({tag, "_req_timeout"}, 32'(imem_req_o), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i = 0;
    while (!instr_valid_o && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_valid_timeout"}, 32'(instr_valid_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    instr_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req",     32'(imem_req_o),    32'd0);
    check("rst_addr",    imem_addr_o,        32'h0);
    check("rst_instr",   instr_o,            32'h0);
    check("rst_pc",      pc_o,               32'h0);
    check("rst_pcplus4", pcplus4_o,          32'h4);
    check("rst_valid",   32'(instr_valid_o), 32'd0);

    // back-to-back fetches at 3 cycles each
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("seq_req",  32'(imem_req_o), 32'd1);
      check("seq_addr", imem_addr_o,     32'(4 * k));
      @(negedge clk);
      check("seq_wait_req",   32'(imem_req_o),    32'd0);
      check("seq_wait_valid", 32'(instr_valid_o), 32'd0);
      @(negedge clk);
      check("seq_valid",   32'(instr_valid_o), 32'd1);
      check("seq_pc",      pc_o,               32'(4 * k));
      check("seq_instr",   instr_o,            32'(4 * k));
      check("seq_pcplus4", pcplus4_o,          32'(4 * k + 4));
      if (k == 2) instr_ready_i = 1'b0;
      else @(negedge clk);
    end

    // back-pressure in HOLD
    lat = 4;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(instr_valid_o), 32'd1);
      check("bp_pc",    pc_o,               32'h8);
      check("bp_instr", instr_o,            32'h8);
      check("bp_req",   32'(imem_req_o),    32'd0);
    end
    instr_ready_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    check("bp_next_req",  32'(imem_req_o), 32'd1);
    check("bp_next_addr", imem_addr_o,     32'hC);

    // redirect in WAIT with slow memory: response dropped, target aligned
    @(negedge clk);
    redirect_i = 1'b1;
    PCTarget_i = 32'h103;
    @(negedge clk);
    redirect_i = 1'b0;
    check("wr_pc",    pc_o,               32'h100);
    check("wr_valid", 32'(instr_valid_o), 32'd0);
    check("wr_req",   32'(imem_req_o),    32'd0);
    wait_req("wr", 10);
    check("wr_no_stale_valid", 32'(saw_valid), 32'd0);
    check("wr_addr", imem_addr_o, 32'h100);
    wait_valid("wr", 10);
    check("wr_first_pc",    pc_o,    32'h100);
    check("wr_first_instr", instr_o, 32'h100);
    lat = 1;

    // redirect from HOLD, then redirect and ready together
    redirect_i = 1'b1;
    PCTarget_i = 32'h20;
    @(negedge clk);
    redirect_i = 1'b0;
    check("hr_addr", imem_addr_o, 32'h20);
    wait_valid("hr", 6);
    check("hr_pc", pc_o, 32'h20);
    redirect_i    = 1'b1;
    PCTarget_i    = 32'h40;
    instr_ready_i = 1'b1;
    @(negedge clk);
    redirect_i    = 1'b0;
    instr_ready_i = 1'b0;
    check("rr_req",  32'(imem_req_o), 32'd1);
    check("rr_addr", imem_addr_o,     32'h40);
    check("rr_pc",   pc_o,            32'h40);
    wait_valid("rr", 6);
    check("rr_instr", instr_o, 32'h40);

    // wrap at the top of the address space
    redirect_i = 1'b1;
    PCTarget_i = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_i = 1'b0;
    check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    wait_valid("wrap", 6);
    check("wrap_pc",      pc_o,      32'hFFFF_FFFC);
    check("wrap_pcplus4", pcplus4_o, 32'h0);
    check("wrap_instr",   instr_o,   32'hFFFF_FFFC);
    instr_ready_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    check("wrap_req",  32'(imem_req_o), 32'd1);
    check("wrap_addr0", imem_addr_o,    32'h0);

    // redirect coinciding with rvalid in WAIT drops the word
    @(negedge clk);
    check("wv_rvalid", 32'(imem_rvalid_i), 32'd1);
    redirect_i = 1'b1;
    PCTarget_i = 32'h300;
    @(negedge clk);
    redirect_i = 1'b0;
    check("wv_req",   32'(imem_req_o),    32'd1);
    check("wv_addr",  imem_addr_o,        32'h300);
    check("wv_valid", 32'(instr_valid_o), 32'd0);

    // reset mid-fetch
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_req",     32'(imem_req_o),    32'd0);
    check("mr_addr",    imem_addr_o,        32'h0);
    check("mr_pc",      pc_o,               32'h0);
    check("mr_pcplus4", pcplus4_o,          32'h4);
    check("mr_instr",   instr_o,            32'h0);
    check("mr_valid",   32'(instr_valid_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_first_req",  32'(imem_req_o), 32'd1);
    check("mr_first_addr", imem_addr_o,     32'h0);
    wait_valid("mr", 6);
    check("mr_first_pc",    pc_o,    32'h0);
    check("mr_first_instr", instr_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
